// File: rtl/aes_host_seq.sv
// aes_host_seq: sequencer between a host and a word-serial AES core.
//
// It accepts one (key, plaintext) job, pulses the core load strobe, streams
// the key and then the plaintext to the core one 32-bit word per cycle
// (most-significant word first), and waits for core_done with a timeout.
// After core_done it pulses the read strobe, collects four ciphertext words,
// and holds them on block_out until the host takes them.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   job handshake; key_in and block_in sampled on accept
//   key_in, block_in      128-bit key and plaintext, bits [127:96] go first
//   out_valid / out_ready result handshake for block_out
//   block_out             128-bit ciphertext, first word read in [127:96]
//   busy                  high whenever the sequencer is not idle
//   timeout_err           sticky: the last job was aborted on timeout
//   core_start_n          active-low one-cycle load strobe to the core
//   core_start_read_n     active-low one-cycle read strobe to the core
//   core_dword_in         word driven to the core (zero when not loading)
//   core_dword_out        word returned by the core
//   core_done             core finished; only looked at while waiting for it
//
// TIMEOUT_CYCLES (1..1023) is the number of waiting cycles allowed without
// core_done before the job is abandoned.

module aes_host_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic         busy,
  output logic         timeout_err,
  output logic         core_start_n,
  output logic         core_start_read_n,
  output logic [31:0]  core_dword_in,
  input  logic [31:0]  core_dword_out,
  input  logic         core_done
);

  typedef enum logic [3:0] {
    IDLE,
    START,
    LOAD_KEY,
    LOAD_PT,
    WAIT_DONE,
    READ_REQ,
    READ,
    OUT,
    ERR
  } state_t;

  // Last waiting cycle: the counter steps onto TIMEOUT_CYCLES at its end.
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t       state;
  state_t       state_next;
  logic [1:0]   word_cnt;
  logic [9:0]   wait_cnt;
  logic [127:0] key_q;
  logic [127:0] pt_q;
  logic         accept;
  logic         timeout_hit;

  function automatic logic [31:0] word_of(input logic [127:0] data,
                                          input logic [1:0]   idx);
    case (idx)
      2'd0:    return data[127:96];
      2'd1:    return data[95:64];
      2'd2:    return data[63:32];
      default: return data[31:0];
    endcase
  endfunction

  assign accept      = in_valid && in_ready;
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (in_valid) state_next = START;
      START:     state_next = LOAD_KEY;
      LOAD_KEY:  if (word_cnt == 2'd3) state_next = LOAD_PT;
      LOAD_PT:   if (word_cnt == 2'd3) state_next = WAIT_DONE;
      // core_done takes priority over an expiring timeout on the same cycle.
      WAIT_DONE: begin
        if (core_done)        state_next = READ_REQ;
        else if (timeout_hit) state_next = ERR;
      end
      READ_REQ:  state_next = READ;
      READ:      if (word_cnt == 2'd3) state_next = OUT;
      OUT:       if (out_ready) state_next = IDLE;
      ERR:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state so an asynchronous reset returns
  // them to their idle values within the same cycle.
  always_comb begin
    in_ready          = 1'b0;
    busy              = 1'b1;
    out_valid         = 1'b0;
    core_start_n      = 1'b1;
    core_start_read_n = 1'b1;
    core_dword_in     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      START:    core_start_n      = 1'b0;
      LOAD_KEY: core_dword_in     = word_of(key_q, word_cnt);
      LOAD_PT:  core_dword_in     = word_of(pt_q, word_cnt);
      READ_REQ: core_start_read_n = 1'b0;
      OUT:      out_valid         = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register sees the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      // The 2-bit counter wraps from 3 to 0 exactly when one phase hands
      // over to the next, so LOAD_PT and READ always start at word 0.
      if (state == LOAD_KEY || state == LOAD_PT || state == READ)
        word_cnt <= word_cnt + 2'd1;
      else
        word_cnt <= '0;
      // Held at zero outside WAIT_DONE, which clears it on entry.
      if (state == WAIT_DONE)
        wait_cnt <= wait_cnt + 10'd1;
      else
        wait_cnt <= '0;
    end
  end

  // NOTE: the job and result registers are reset too, so a job started after
  // reset can never observe data left over from an aborted one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q       <= '0;
      pt_q        <= '0;
      block_out   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        key_q <= key_in;
        pt_q  <= block_in;
      end

      if (accept)
        timeout_err <= 1'b0;
      else if (state == WAIT_DONE && !core_done && timeout_hit)
        timeout_err <= 1'b1;

      if (state == READ) begin
        case (word_cnt)
          2'd0:    block_out[127:96] <= core_dword_out;
          2'd1:    block_out[95:64]  <= core_dword_out;
          2'd2:    block_out[63:32]  <= core_dword_out;
          default: block_out[31:0]   <= core_dword_out;
        endcase
      end
    end
  end

endmodule

// File: doc/aes_host_seq.md
AES_HOST_SEQ -- requirements
Module: aes_host_seq

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, maximum WAIT_DONE cycles before abort (range 1..1023, 10-bit counter).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  host offers key_in/block_in.
REQ-005 in_ready  output  1  sequencer accepts a job.
REQ-006 key_in  input  128  cipher key, bits [127:96] = first word.
REQ-007 block_in  input  128  plaintext, bits [127:96] = first word.
REQ-008 out_valid  output  1  block_out holds ciphertext.
REQ-009 out_ready  input  1  host consumes block_out.
REQ-010 block_out  output  128  ciphertext, first word read lands in [127:96].
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_err  output  1  sticky flag: last job aborted on timeout.
REQ-013 core_start_n  output  1  active-low load strobe to the AES core.
REQ-014 core_start_read_n  output  1  active-low read strobe to the AES core.
REQ-015 core_dword_in  output  32  word driven to the core.
REQ-016 core_dword_out  input  32  word returned by the core.
REQ-017 core_done  input  1  core finished encryption.

Function
REQ-018 States: IDLE, START, LOAD_KEY, LOAD_PT, WAIT_DONE, READ_REQ, READ, OUT, ERR; 2-bit word counter for LOAD_KEY/LOAD_PT/READ.
REQ-019 in_ready = 1 only in IDLE; accept = in_valid && in_ready; key_in/block_in registered on accept.
REQ-020 Accept at cycle T -> START at T+1: core_start_n=0 for exactly one cycle, core_dword_in=0.
REQ-021 LOAD_KEY T+2..T+5: core_dword_in = key[127:96], [95:64], [63:32], [31:0], one per cycle.
REQ-022 LOAD_PT T+6..T+9: core_dword_in = block[127:96] ... [31:0], one per cycle; core_dword_in=0 in all other states.
REQ-023 WAIT_DONE from T+10; core_done sampled only here; core_done in any other state is ignored.
REQ-024 core_done=1 at cycle D in WAIT_DONE -> READ_REQ at D+1: core_start_read_n=0 for exactly one cycle.
REQ-025 READ D+2..D+5: core_dword_out captured into block_out [127:96], [95:64], [63:32], [31:0] in order.
REQ-026 OUT from D+6: out_valid=1, block_out stable until out_valid && out_ready; then IDLE next cycle.
REQ-027 out_ready high on first OUT cycle completes handshake that cycle (minimum one out_valid cycle).
REQ-028 Timeout counter cleared on WAIT_DONE entry, increments each WAIT_DONE cycle without core_done; reaching TIMEOUT_CYCLES -> ERR.
REQ-029 core_done on the same cycle the counter reaches TIMEOUT_CYCLES: done wins, go to READ_REQ.
REQ-030 ERR lasts one cycle, sets timeout_err=1, then IDLE; out_valid never asserted for aborted job.
REQ-031 timeout_err cleared on next accept; otherwise holds.
REQ-032 in_valid while busy: ignored, no state change, inputs not sampled.
REQ-033 core_start_n and core_start_read_n never low simultaneously; both 1 outside START/READ_REQ.

Reset
REQ-034 reset_n low, asynchronously: state=IDLE, counters=0, in_ready=1 once reset_n is high, out_valid=0, block_out=0, busy=0, timeout_err=0, core_start_n=1, core_start_read_n=1, core_dword_in=0.
REQ-035 Reset mid-job (any state) aborts immediately; first in_valid after release is a fresh job with no residue.

Verification
REQ-036 FIPS-197 key 000102..0f, pt 00112233..ff, model asserts done 40 cycles after last load -> block_out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at D+6.
REQ-037 Word order: key 0x0123..., pt 0xA5A5... -> core_dword_in sequence 0, key words MSW-first, pt words MSW-first on T+1..T+9.
REQ-038 out_ready held low 20 cycles -> out_valid and block_out stable 20 cycles; in_valid during that ignored, in_ready=0.
REQ-039 TIMEOUT_CYCLES=16, core_done never asserted -> ERR at T+26, timeout_err=1, no out_valid; next accept clears timeout_err.
REQ-040 reset_n low during LOAD_PT (T+7) -> all outputs at reset values same cycle; post-release job completes correctly.
REQ-041 core_done pulsed during LOAD_KEY and on exact timeout cycle -> first ignored, second proceeds to READ_REQ, timeout_err=0.
